alu_step_sequencer: RTL and testbench
=====================================

ALU_STEP_SEQUENCER -- requirements
Module: alu_step_sequencer

Interface
- REQ-001 Parameter: DATA_W, default 32, instruction word width.
- REQ-002 Parameter: NUM_REGS, default 16, general registers; REG_IDX_W = clog2(NUM_REGS).
- REQ-003 clk  in  1  single clock; all state changes on rising edge.
- REQ-004 reset  in  1  asynchronous, active-low.
- REQ-005 start  in  1  one-cycle request to run one fetch/execute sequence.
- REQ-006 ir  in  DATA_W  datapath IR contents; opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- REQ-007 mem_ready  in  1  memory read complete.
- REQ-008 busy, done, illegal  out  1 each  sequence active; one-cycle completion pulse; one-cycle bad-opcode pulse.
- REQ-009 reg_out, reg_in  out  NUM_REGS each  one-hot register bus-drive and load enables.
- REQ-010 pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in  out  1 each  datapath strobes.
- REQ-011 alu_op  out  13  one-hot: AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT (bit 12 = AND, bit 0 = NOT).
- REQ-012 step  out  4  current state encoding, for debug.

Function
- REQ-013 States: IDLE, T0–T6, DONE; all outputs are registered decodes of state, active for exactly that state's cycle.
- REQ-014 IDLE: start=1 -> T0 next cycle; start while busy is ignored.
- REQ-015 T0: pc_out, mar_in, inc_pc, pc_in.
- REQ-016 T1: read, mdr_in.
- REQ-017 T2: mdr_out, ir_in; ir is sampled (opcode, Ra, Rb, Rc latched) on entry to T3.
- REQ-018 Binary ops (ADD=3, SUB=4, AND=5, OR=6, ROR=7, ROL=8, SHR=9, SHRA=10, SHL=11):
  - T3: reg_out[Rb], y_in.
  - T4: reg_out[Rc], alu_op, z_in.
  - T5: zlow_out, reg_in[Ra].
  - Then DONE.
- REQ-019 Unary ops (NEG=17, NOT=18):
  - T3: reg_out[Rb], alu_op, z_in.
  - T4: zlow_out, reg_in[Ra].
  - Then DONE.
- REQ-020 MUL=15 / DIV=16:
  - T3: reg_out[Rb], y_in.
  - T4: reg_out[Rc], alu_op, z_in.
  - T5: zlow_out, lo_in.
  - T6: zhigh_out, hi_in.
  - Then DONE.
- REQ-021 Any other opcode: illegal=1 in T3; no register or Z strobes; then DONE.
- REQ-022 DONE: done=1 for one cycle, then IDLE; busy=1 in every state except IDLE.
- REQ-023 Register index >= NUM_REGS drives no reg_out/reg_in bit and raises illegal in T3.

Reset
- REQ-024 reset low: state=IDLE and every output 0, immediately (asynchronously), including mid-sequence; no done pulse for an aborted sequence.
- REQ-025 First start is accepted on the first rising edge after reset deasserts.

Configuration
- REQ-026 Macro SEQ_MEM_WAIT_EN.
  - Defined: T1 holds (read and mdr_in stay high) until mem_ready=1, then advances.
  - Undefined: T1 lasts exactly one cycle and mem_ready is ignored.

Structure
- REQ-027 Shared package seq_pkg holds:
  - state enumeration;
  - opcode constants;
  - alu_op bit positions;
  - IR field bit positions.
- REQ-028 One sub-module, seq_decoder: combinational opcode -> op class (binary, unary, muldiv, illegal) plus alu_op one-hot.

Verification
- REQ-029 ir=0x92800000 (NOT, Ra=5, Rb=0):
  - T3: reg_out=0x0001, alu_op NOT, z_in.
  - T4: zlow_out, reg_in=0x0020.
  - done 6 cycles after start.
- REQ-030 ir=0x18918000 (ADD, Ra=1, Rb=2, Rc=3):
  - T3: reg_out=0x0004 with y_in.
  - T4: reg_out=0x0008 with ADD and z_in.
  - T5: reg_in=0x0002.
- REQ-031 ir=0x78338000 (MUL, Rb=6, Rc=7):
  - T5: zlow_out with lo_in.
  - T6: zhigh_out with hi_in.
  - no reg_in bit ever set.
- REQ-032 ir=0xF8000000: illegal and done pulse; z_in and all reg_in bits never asserted.
- REQ-033 reset pulled low during T4 of ADD: all outputs 0 within same cycle, step=IDLE, no done; subsequent start runs normally.
- REQ-034 With SEQ_MEM_WAIT_EN, mem_ready held low 3 cycles: read high 4 cycles in T1; total sequence 3 cycles longer.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the ALU step sequencer: FSM state encoding,
// opcode values, alu_op one-hot bit positions, IR field positions and
// the bundle of single-bit datapath strobes.
package seq_pkg;

    // Sequencer states; the encoding is exported on the step debug port.
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_DONE = 4'd8
    } state_e;

    // Execution class of an opcode; selects the T3..T6 micro-step path.
    typedef enum logic [1:0] {
        CLS_BINARY,
        CLS_UNARY,
        CLS_MULDIV,
        CLS_ILLEGAL
    } op_class_e;

    // Opcode values (IR[31:27]).
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SHRA = 5'd10;
    localparam logic [4:0] OP_SHL  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16;
    localparam logic [4:0] OP_NEG  = 5'd17;
    localparam logic [4:0] OP_NOT  = 5'd18;

    // alu_op one-hot bit positions.
    localparam int ALU_OP_W = 13;
    localparam int ALU_AND  = 12;
    localparam int ALU_OR   = 11;
    localparam int ALU_ADD  = 10;
    localparam int ALU_SUB  = 9;
    localparam int ALU_MUL  = 8;
    localparam int ALU_DIV  = 7;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 5;
    localparam int ALU_SHL  = 4;
    localparam int ALU_ROR  = 3;
    localparam int ALU_ROL  = 2;
    localparam int ALU_NEG  = 1;
    localparam int ALU_NOT  = 0;

    // IR field positions.
    localparam int IR_OPC_MSB  = 31;
    localparam int IR_OPC_LSB  = 27;
    localparam int IR_RA_MSB   = 26;
    localparam int IR_RA_LSB   = 23;
    localparam int IR_RB_MSB   = 22;
    localparam int IR_RB_LSB   = 19;
    localparam int IR_RC_MSB   = 18;
    localparam int IR_RC_LSB   = 15;
    localparam int REG_FIELD_W = 4;

    // Single-bit outputs, registered together.
    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic zhigh_out;
        logic lo_in;
        logic hi_in;
        logic busy;
        logic done;
        logic illegal;
    } strobes_t;

endpackage

// File: rtl/alu_step_sequencer_if.sv
// Control bus between the step sequencer and the datapath/host.
// slave = sequencer side, master = the side issuing start/ir/mem_ready.
interface alu_step_sequencer_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
);
    logic                start;
    logic [DATA_W-1:0]   ir;
    logic                mem_ready;
    logic                busy;
    logic                done;
    logic                illegal;
    logic [NUM_REGS-1:0] reg_out;
    logic [NUM_REGS-1:0] reg_in;
    logic                pc_out;
    logic                pc_in;
    logic                inc_pc;
    logic                mar_in;
    logic                read;
    logic                mdr_in;
    logic                mdr_out;
    logic                ir_in;
    logic                y_in;
    logic                z_in;
    logic                zlow_out;
    logic                zhigh_out;
    logic                lo_in;
    logic                hi_in;
    logic [12:0]         alu_op;
    logic [3:0]          step;

    modport slave (
        input  start, ir, mem_ready,
        output busy, done, illegal, reg_out, reg_in,
        output pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in,
        output y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in, alu_op, step
    );

    modport master (
        output start, ir, mem_ready,
        input  busy, done, illegal, reg_out, reg_in,
        input  pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in,
        input  y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in, alu_op, step
    );
endinterface

// File: rtl/seq_decoder.sv
// Combinational opcode decode: execution class plus one-hot ALU function.
module seq_decoder
    import seq_pkg::*;
(
    input  logic [4:0]          opcode,
    output op_class_e           op_class,
    output logic [ALU_OP_W-1:0] alu_op
);

    // Map each opcode to its class and ALU function; unknown opcodes are illegal.
    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_op   = '0;
        case (opcode)
            OP_ADD:  begin op_class = CLS_BINARY; alu_op[ALU_ADD]  = 1'b1; end
            OP_SUB:  begin op_class = CLS_BINARY; alu_op[ALU_SUB]  = 1'b1; end
            OP_AND:  begin op_class = CLS_BINARY; alu_op[ALU_AND]  = 1'b1; end
            OP_OR:   begin op_class = CLS_BINARY; alu_op[ALU_OR]   = 1'b1; end
            OP_ROR:  begin op_class = CLS_BINARY; alu_op[ALU_ROR]  = 1'b1; end
            OP_ROL:  begin op_class = CLS_BINARY; alu_op[ALU_ROL]  = 1'b1; end
            OP_SHR:  begin op_class = CLS_BINARY; alu_op[ALU_SHR]  = 1'b1; end
            OP_SHRA: begin op_class = CLS_BINARY; alu_op[ALU_SHRA] = 1'b1; end
            OP_SHL:  begin op_class = CLS_BINARY; alu_op[ALU_SHL]  = 1'b1; end
            OP_MUL:  begin op_class = CLS_MULDIV; alu_op[ALU_MUL]  = 1'b1; end
            OP_DIV:  begin op_class = CLS_MULDIV; alu_op[ALU_DIV]  = 1'b1; end
            OP_NEG:  begin op_class = CLS_UNARY;  alu_op[ALU_NEG]  = 1'b1; end
            OP_NOT:  begin op_class = CLS_UNARY;  alu_op[ALU_NOT]  = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_step_sequencer.sv
// Fetch/execute step sequencer for a bus-based ALU datapath.
// Every output is a registered decode of the next state, so each strobe is
// high for exactly the cycle its state occupies.
// Build option: define SEQ_MEM_WAIT_EN to stretch T1 until mem_ready=1;
// otherwise T1 is a single cycle and mem_ready is ignored.
module alu_step_sequencer
    import seq_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_step_sequencer_if.slave  bus
);

    state_e                    state_q, state_d;
    logic [4:0]                opc_q, opc_d;
    logic [REG_FIELD_W-1:0]    ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    strobes_t                  strobe_q, strobe_d;
    logic [NUM_REGS-1:0]       reg_out_q, reg_out_d, reg_in_q, reg_in_d;
    logic [ALU_OP_W-1:0]       alu_op_q, alu_op_d, dec_alu_op;
    logic [NUM_REGS-1:0]       ra_hot, rb_hot, rc_hot;
    op_class_e                 dec_class;
    logic                      idx_bad, seq_illegal;
    logic                      unused_in;

    // IR fields are captured on the T2->T3 edge; while in T2 the live IR is
    // forwarded so the T3 outputs already reflect the instruction.
    always_comb begin
        opc_d = opc_q;
        ra_d  = ra_q;
        rb_d  = rb_q;
        rc_d  = rc_q;
        if (state_q == ST_T2) begin
            opc_d = bus.ir[IR_OPC_MSB:IR_OPC_LSB];
            ra_d  = bus.ir[IR_RA_MSB:IR_RA_LSB];
            rb_d  = bus.ir[IR_RB_MSB:IR_RB_LSB];
            rc_d  = bus.ir[IR_RC_MSB:IR_RC_LSB];
        end
    end

    seq_decoder u_decoder (
        .opcode   (opc_d),
        .op_class (dec_class),
        .alu_op   (dec_alu_op)
    );

    // One-hot register selects; an index with no matching register yields zero.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_hot
        assign ra_hot[gi] = (32'(ra_d) == gi);
        assign rb_hot[gi] = (32'(rb_d) == gi);
        assign rc_hot[gi] = (32'(rc_d) == gi);
    end

    // Flag out-of-range indices only for the fields the op class actually uses.
    always_comb begin
        idx_bad = 1'b0;
        case (dec_class)
            CLS_BINARY: idx_bad = ~|ra_hot | ~|rb_hot | ~|rc_hot;
            CLS_UNARY:  idx_bad = ~|ra_hot | ~|rb_hot;
            CLS_MULDIV: idx_bad = ~|rb_hot | ~|rc_hot;
            default:    idx_bad = 1'b0;
        endcase
        seq_illegal = (dec_class == CLS_ILLEGAL) || idx_bad;
    end

    // Next-state logic and output decode of the state being entered.
    always_comb begin
        state_d   = state_q;
        strobe_d  = '0;
        reg_out_d = '0;
        reg_in_d  = '0;
        alu_op_d  = '0;

        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
`ifdef SEQ_MEM_WAIT_EN
            ST_T1:   state_d = bus.mem_ready ? ST_T2 : ST_T1;
`else
            ST_T1:   state_d = ST_T2;
`endif
            ST_T2:   state_d = ST_T3;
            ST_T3:   state_d = seq_illegal ? ST_DONE : ST_T4;
            ST_T4:   state_d = (dec_class == CLS_UNARY) ? ST_DONE : ST_T5;
            ST_T5:   state_d = (dec_class == CLS_MULDIV) ? ST_T6 : ST_DONE;
            ST_T6:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        strobe_d.busy = (state_d != ST_IDLE);

        case (state_d)
            ST_T0: begin
                strobe_d.pc_out = 1'b1;
                strobe_d.mar_in = 1'b1;
                strobe_d.inc_pc = 1'b1;
                strobe_d.pc_in  = 1'b1;
            end
            ST_T1: begin
                strobe_d.read   = 1'b1;
                strobe_d.mdr_in = 1'b1;
            end
            ST_T2: begin
                strobe_d.mdr_out = 1'b1;
                strobe_d.ir_in   = 1'b1;
            end
            ST_T3: begin
                if (seq_illegal) begin
                    strobe_d.illegal = 1'b1;
                end else if (dec_class == CLS_UNARY) begin
                    reg_out_d     = rb_hot;
                    alu_op_d      = dec_alu_op;
                    strobe_d.z_in = 1'b1;
                end else begin
                    reg_out_d     = rb_hot;
                    strobe_d.y_in = 1'b1;
                end
            end
            ST_T4: begin
                if (dec_class == CLS_UNARY) begin
                    strobe_d.zlow_out = 1'b1;
                    reg_in_d          = ra_hot;
                end else begin
                    reg_out_d     = rc_hot;
                    alu_op_d      = dec_alu_op;
                    strobe_d.z_in = 1'b1;
                end
            end
            ST_T5: begin
                strobe_d.zlow_out = 1'b1;
                if (dec_class == CLS_MULDIV) strobe_d.lo_in = 1'b1;
                else                         reg_in_d = ra_hot;
            end
            ST_T6: begin
                strobe_d.zhigh_out = 1'b1;
                strobe_d.hi_in     = 1'b1;
            end
            ST_DONE: strobe_d.done = 1'b1;
            default: ;
        endcase
    end

    // State, captured IR fields and registered outputs; reset clears all at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            opc_q     <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            strobe_q  <= '0;
            reg_out_q <= '0;
            reg_in_q  <= '0;
            alu_op_q  <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            rc_q      <= rc_d;
            strobe_q  <= strobe_d;
            reg_out_q <= reg_out_d;
            reg_in_q  <= reg_in_d;
            alu_op_q  <= alu_op_d;
        end
    end

    assign bus.busy      = strobe_q.busy;
    assign bus.done      = strobe_q.done;
    assign bus.illegal   = strobe_q.illegal;
    assign bus.pc_out    = strobe_q.pc_out;
    assign bus.pc_in     = strobe_q.pc_in;
    assign bus.inc_pc    = strobe_q.inc_pc;
    assign bus.mar_in    = strobe_q.mar_in;
    assign bus.read      = strobe_q.read;
    assign bus.mdr_in    = strobe_q.mdr_in;
    assign bus.mdr_out   = strobe_q.mdr_out;
    assign bus.ir_in     = strobe_q.ir_in;
    assign bus.y_in      = strobe_q.y_in;
    assign bus.z_in      = strobe_q.z_in;
    assign bus.zlow_out  = strobe_q.zlow_out;
    assign bus.zhigh_out = strobe_q.zhigh_out;
    assign bus.lo_in     = strobe_q.lo_in;
    assign bus.hi_in     = strobe_q.hi_in;
    assign bus.reg_out   = reg_out_q;
    assign bus.reg_in    = reg_in_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.step      = state_q;

    // IR bits outside the decoded fields (and mem_ready in the no-wait build) are don't-care.
    assign unused_in = ^{bus.ir, bus.mem_ready};

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer; expected values are hand-derived
// from the instruction encodings. Cycle k=1 is the first cycle after the
// edge that accepts start (T0).
module tb_alu_step_sequencer;

`ifdef SEQ_MEM_WAIT_EN
    localparam int W = 3;   // extra T1 cycles from holding mem_ready low
`else
    localparam int W = 0;
`endif
    localparam int NCYC = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_step_sequencer_if #(.DATA_W(32), .NUM_REGS(16)) bus ();

    alu_step_sequencer #(.DATA_W(32), .NUM_REGS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [13:0] strobes;
    assign strobes = {bus.pc_out, bus.pc_in, bus.inc_pc, bus.mar_in, bus.read,
                      bus.mdr_in, bus.mdr_out, bus.ir_in, bus.y_in, bus.z_in,
                      bus.zlow_out, bus.zhigh_out, bus.lo_in, bus.hi_in};

    logic [33:0] ctrl_all;
    assign ctrl_all = {strobes, bus.busy, bus.done, bus.illegal, bus.alu_op, bus.step};

    logic [3:0]  cap_step [NCYC+1];
    logic [13:0] cap_strb [NCYC+1];
    logic [15:0] cap_rout [NCYC+1];
    logic [15:0] cap_rin  [NCYC+1];
    logic [12:0] cap_alu  [NCYC+1];
    logic        cap_busy [NCYC+1];
    logic        cap_ill  [NCYC+1];
    int          done_k, done_cnt, ill_cnt, read_cnt;
    logic [15:0] rin_or;
    logic        z_or;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one start and capture NCYC cycles of outputs.
    task automatic run_seq(input logic [31:0] ir_val, input int restart_k);
        bus.ir        = ir_val;
        bus.start     = 1'b1;
        bus.mem_ready = 1'b0;
        done_k = -1; done_cnt = 0; ill_cnt = 0; read_cnt = 0;
        rin_or = '0; z_or = 1'b0;
        for (int k = 1; k <= NCYC; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.start = 1'b0;
            if (k == restart_k) bus.start = 1'b1;
            if (restart_k > 0 && k == restart_k + 1) bus.start = 1'b0;
            cap_step[k] = bus.step;
            cap_strb[k] = strobes;
            cap_rout[k] = bus.reg_out;
            cap_rin[k]  = bus.reg_in;
            cap_alu[k]  = bus.alu_op;
            cap_busy[k] = bus.busy;
            cap_ill[k]  = bus.illegal;
            if (bus.done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (bus.illegal) ill_cnt++;
            if (bus.read) read_cnt++;
            rin_or = rin_or | bus.reg_in;
            z_or   = z_or | bus.z_in;
            if (k == 4 + W) bus.ir = ~ir_val;          // IR must already be latched
            if (W > 0 && k == 2 + W) bus.mem_ready = 1'b1;
        end
        $display("[TB] seq ir=%08h done_at=%0d done_pulses=%0d illegal_pulses=%0d",
                 ir_val, done_k, done_cnt, ill_cnt);
    endtask

    function automatic int after_done();
        return (done_k > 0 && done_k < NCYC) ? done_k + 1 : NCYC;
    endfunction

    initial begin
        logic done_seen;
        reset = 1'b0; bus.start = 1'b0; bus.ir = '0; bus.mem_ready = 1'b1;
        #3;
        chk("rst_ctrl", 64'(ctrl_all), 64'h0);
        chk("rst_regs", 64'({bus.reg_out, bus.reg_in}), 64'h0);
        bus.start = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_start_ignored", 64'(ctrl_all), 64'h0);
        bus.start = 1'b0;
        reset = 1'b1;

        // NOT R5, R0
        run_seq(32'h9280_0000, 0);
        chk("not_done_at", 64'(done_k), 64'(6 + W));
        chk("not_t0_strb", 64'(cap_strb[1]), 64'h3C00);
        chk("not_t0_step", 64'(cap_step[1]), 64'h1);
        chk("not_t1_strb", 64'(cap_strb[2]), 64'h0300);
        chk("not_read_cycles", 64'(read_cnt), 64'(1 + W));
        chk("not_t2_strb", 64'(cap_strb[3 + W]), 64'h00C0);
        chk("not_t3_rout", 64'(cap_rout[4 + W]), 64'h0001);
        chk("not_t3_alu", 64'(cap_alu[4 + W]), 64'h0001);
        chk("not_t3_strb", 64'(cap_strb[4 + W]), 64'h0010);
        chk("not_t3_step", 64'(cap_step[4 + W]), 64'h4);
        chk("not_t4_strb", 64'(cap_strb[5 + W]), 64'h0008);
        chk("not_t4_rin", 64'(cap_rin[5 + W]), 64'h0020);
        chk("not_t4_alu", 64'(cap_alu[5 + W]), 64'h0);
        chk("not_done_cnt", 64'(done_cnt), 64'h1);
        chk("not_idle_step", 64'(cap_step[after_done()]), 64'h0);
        chk("not_idle_busy", 64'(cap_busy[after_done()]), 64'h0);

        // ADD R1, R2, R3 with a second start while busy
        run_seq(32'h1891_8000, 2);
        chk("add_done_at", 64'(done_k), 64'(7 + W));
        chk("add_t3_rout", 64'(cap_rout[4 + W]), 64'h0004);
        chk("add_t3_strb", 64'(cap_strb[4 + W]), 64'h0020);
        chk("add_t4_rout", 64'(cap_rout[5 + W]), 64'h0008);
        chk("add_t4_alu", 64'(cap_alu[5 + W]), 64'h0400);
        chk("add_t4_strb", 64'(cap_strb[5 + W]), 64'h0010);
        chk("add_t5_rin", 64'(cap_rin[6 + W]), 64'h0002);
        chk("add_t5_strb", 64'(cap_strb[6 + W]), 64'h0008);
        chk("add_done_cnt", 64'(done_cnt), 64'h1);
        chk("add_no_restart", 64'(cap_step[after_done()]), 64'h0);

        // MUL R6, R7
        run_seq(32'h7833_8000, 0);
        chk("mul_done_at", 64'(done_k), 64'(8 + W));
        chk("mul_t3_rout", 64'(cap_rout[4 + W]), 64'h0040);
        chk("mul_t4_rout", 64'(cap_rout[5 + W]), 64'h0080);
        chk("mul_t4_alu", 64'(cap_alu[5 + W]), 64'h0100);
        chk("mul_t5_strb", 64'(cap_strb[6 + W]), 64'h000A);
        chk("mul_t6_strb", 64'(cap_strb[7 + W]), 64'h0005);
        chk("mul_rin_never", 64'(rin_or), 64'h0);

        // Opcode 31: illegal
        run_seq(32'hF800_0000, 0);
        chk("ill31_done_at", 64'(done_k), 64'(5 + W));
        chk("ill31_t3_flag", 64'(cap_ill[4 + W]), 64'h1);
        chk("ill31_pulses", 64'(ill_cnt), 64'h1);
        chk("ill31_no_z", 64'(z_or), 64'h0);
        chk("ill31_no_rin", 64'(rin_or), 64'h0);
        chk("ill31_t3_rout", 64'(cap_rout[4 + W]), 64'h0);

        // Opcode 12: gap between SHL and MUL, illegal
        run_seq(32'h6000_0000, 0);
        chk("ill12_done_at", 64'(done_k), 64'(5 + W));
        chk("ill12_pulses", 64'(ill_cnt), 64'h1);

        // DIV, SHRA, NEG: class paths and ALU bit positions
        run_seq(32'h8000_0000, 0);
        chk("div_done_at", 64'(done_k), 64'(8 + W));
        chk("div_t4_alu", 64'(cap_alu[5 + W]), 64'h0080);
        run_seq(32'h5000_0000, 0);
        chk("shra_done_at", 64'(done_k), 64'(7 + W));
        chk("shra_t4_alu", 64'(cap_alu[5 + W]), 64'h0020);
        run_seq(32'h8800_0000, 0);
        chk("neg_done_at", 64'(done_k), 64'(6 + W));
        chk("neg_t3_alu", 64'(cap_alu[4 + W]), 64'h0002);
        chk("neg_ill_none", 64'(ill_cnt), 64'h0);

        // Reset asserted in the middle of T4 of an ADD
        bus.mem_ready = 1'b1;
        bus.ir = 32'h1891_8000;
        bus.start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.start = 1'b0;
        end
        chk("rstmid_pre_step", 64'(bus.step), 64'h5);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_ctrl", 64'(ctrl_all), 64'h0);
        chk("rstmid_regs", 64'({bus.reg_out, bus.reg_in}), 64'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        done_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            done_seen = done_seen | bus.done;
        end
        chk("rstmid_no_done", 64'(done_seen), 64'h0);
        chk("rstmid_idle", 64'(bus.step), 64'h0);
        $display("[TB] seq ir=18918000 aborted by reset in T4");

        run_seq(32'h1891_8000, 0);
        chk("add2_done_at", 64'(done_k), 64'(7 + W));
        chk("add2_t5_rin", 64'(cap_rin[6 + W]), 64'h0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
